// File: rtl/lane_mem_arbiter_pkg.sv
// lane_mem_arbiter_pkg: parameter defaults, derived widths and slot table entry type.
package lane_mem_arbiter_pkg;
  localparam int NUM_LANES_DEF      = 16;
  localparam int ARCH_LEN_DEF       = 32;
  localparam int DMEM_DATA_BITS_DEF = 32;
  localparam int DMEM_TAG_BITS_DEF  = 32;
  localparam int MAX_INFLIGHT_DEF   = 8;
  localparam int MASK_BITS_DEF      = DMEM_DATA_BITS_DEF / 8;
  localparam int SIZE_BITS_DEF      = $clog2($clog2(MASK_BITS_DEF) + 1);
  localparam int SLOT_BITS_DEF      = $clog2(MAX_INFLIGHT_DEF);
  localparam int LANE_BITS_DEF      = $clog2(NUM_LANES_DEF);
  localparam int CNT_BITS_DEF       = $clog2(MAX_INFLIGHT_DEF + 1);
  typedef struct packed {
    logic [LANE_BITS_DEF-1:0]     lane_id;
    logic [DMEM_TAG_BITS_DEF-1:0] lane_tag;
  } slot_entry_t;
endpackage

// File: rtl/lane_mem_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts at ptr_i and wraps.
module rr_arbiter #(
  parameter int N = 16,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);
  always_comb begin
    grant_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) grant_o = N'(1) << ((int'(ptr_i) + k) % N);
  end
endmodule

// File: rtl/lane_mem_arbiter.sv
// lane_mem_arbiter: funnels per-lane memory requests into one tagged downstream port
// and routes responses back to the issuing lane via an in-flight slot table.
module lane_mem_arbiter
  import lane_mem_arbiter_pkg::*;
#(
  parameter int NUM_LANES      = NUM_LANES_DEF,
  parameter int ARCH_LEN       = ARCH_LEN_DEF,
  parameter int DMEM_DATA_BITS = DMEM_DATA_BITS_DEF,
  parameter int DMEM_TAG_BITS  = DMEM_TAG_BITS_DEF,
  parameter int MAX_INFLIGHT   = MAX_INFLIGHT_DEF,
  localparam int MASK_BITS = DMEM_DATA_BITS / 8,
  localparam int SIZE_BITS = $clog2($clog2(MASK_BITS) + 1),
  localparam int SLOT_BITS = $clog2(MAX_INFLIGHT),
  localparam int CNT_BITS  = $clog2(MAX_INFLIGHT + 1),
  localparam int LANE_BITS = $clog2(NUM_LANES)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_LANES-1:0]                lane_req_valid,
  output logic [NUM_LANES-1:0]                lane_req_ready,
  input  logic [NUM_LANES-1:0]                lane_req_bits_store,
  input  logic [NUM_LANES*ARCH_LEN-1:0]       lane_req_bits_address,
  input  logic [NUM_LANES*SIZE_BITS-1:0]      lane_req_bits_size,
  input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] lane_req_bits_data,
  input  logic [NUM_LANES*MASK_BITS-1:0]      lane_req_bits_mask,
  input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  lane_req_bits_tag,
  output logic [NUM_LANES-1:0]                lane_resp_valid,
  input  logic [NUM_LANES-1:0]                lane_resp_ready,
  output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  lane_resp_bits_tag,
  output logic [NUM_LANES*DMEM_DATA_BITS-1:0] lane_resp_bits_data,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_req_bits_store,
  output logic [ARCH_LEN-1:0]                 mem_req_bits_address,
  output logic [SIZE_BITS-1:0]                mem_req_bits_size,
  output logic [DMEM_DATA_BITS-1:0]           mem_req_bits_data,
  output logic [MASK_BITS-1:0]                mem_req_bits_mask,
  output logic [SLOT_BITS-1:0]                mem_req_bits_tag,
  input  logic                                mem_resp_valid,
  output logic                                mem_resp_ready,
  input  logic [SLOT_BITS-1:0]                mem_resp_bits_tag,
  input  logic [DMEM_DATA_BITS-1:0]           mem_resp_bits_data,
  output logic [CNT_BITS-1:0]                 inflight_count,
  output logic                                idle,
  output logic                                error
);
  logic [MAX_INFLIGHT-1:0] busy_q, busy_d, alloc_vec, free_vec;
  logic [LANE_BITS-1:0]    rr_ptr_q, rr_ptr_d, grant_idx, rsp_lane;
  logic [NUM_LANES-1:0]    grant;
  logic [SLOT_BITS-1:0]    free_slot, out_slot_q;
  logic                    out_valid_q, out_valid_d, error_q, error_d;
  logic                    has_free, can_grant, granted, rsp_busy, rsp_hit;
  logic                    out_store_q;
  logic [ARCH_LEN-1:0]       out_addr_q;
  logic [SIZE_BITS-1:0]      out_size_q;
  logic [DMEM_DATA_BITS-1:0] out_data_q;
  logic [MASK_BITS-1:0]      out_mask_q;
  slot_entry_t             table_q [MAX_INFLIGHT];
  slot_entry_t             rsp_entry;

  always_comb begin
    has_free  = 1'b0;
    free_slot = '0;
    for (int s = MAX_INFLIGHT - 1; s >= 0; s--)
      if (!busy_q[s]) begin
        has_free  = 1'b1;
        free_slot = SLOT_BITS'(s);
      end
  end

  // A grant needs a slot and room in the output register (or it draining this cycle).
  assign can_grant = has_free && (!out_valid_q || mem_req_ready);

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .req_i  (lane_req_valid & {NUM_LANES{can_grant}}),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant)
  );

  assign lane_req_ready = grant;
  assign granted        = |grant;

  always_comb begin
    grant_idx = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (grant[l]) grant_idx = LANE_BITS'(l);
  end

  assign rr_ptr_d = !granted ? rr_ptr_q :
                    (grant_idx == LANE_BITS'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;

  assign rsp_busy  = (int'(mem_resp_bits_tag) < MAX_INFLIGHT) && busy_q[mem_resp_bits_tag];
  assign rsp_hit   = mem_resp_valid && rsp_busy;
  assign rsp_entry = table_q[mem_resp_bits_tag];
  assign rsp_lane  = LANE_BITS'(rsp_entry.lane_id);

  assign lane_resp_valid     = rsp_hit ? NUM_LANES'(1) << rsp_lane : '0;
  assign lane_resp_bits_tag  = {NUM_LANES{DMEM_TAG_BITS'(rsp_entry.lane_tag)}};
  assign lane_resp_bits_data = {NUM_LANES{mem_resp_bits_data}};
  assign mem_resp_ready      = rsp_busy ? lane_resp_ready[rsp_lane] : 1'b1;

  // Allocation sees the pre-free busy vector, so a freed slot is reusable only next cycle.
  assign alloc_vec   = granted ? MAX_INFLIGHT'(1) << free_slot : '0;
  assign free_vec    = (rsp_hit && mem_resp_ready) ? MAX_INFLIGHT'(1) << mem_resp_bits_tag : '0;
  assign busy_d      = (busy_q & ~free_vec) | alloc_vec;
  assign out_valid_d = granted || (out_valid_q && !mem_req_ready);
  assign error_d     = error_q || (mem_resp_valid && !rsp_busy);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (granted) begin
      out_store_q <= lane_req_bits_store[grant_idx];
      out_addr_q  <= lane_req_bits_address[ARCH_LEN*int'(grant_idx) +: ARCH_LEN];
      out_size_q  <= lane_req_bits_size[SIZE_BITS*int'(grant_idx) +: SIZE_BITS];
      out_data_q  <= lane_req_bits_data[DMEM_DATA_BITS*int'(grant_idx) +: DMEM_DATA_BITS];
      out_mask_q  <= lane_req_bits_mask[MASK_BITS*int'(grant_idx) +: MASK_BITS];
      out_slot_q  <= free_slot;
      table_q[free_slot] <= '{lane_id:  LANE_BITS_DEF'(grant_idx),
                              lane_tag: DMEM_TAG_BITS_DEF'(lane_req_bits_tag[DMEM_TAG_BITS*int'(grant_idx) +: DMEM_TAG_BITS])};
    end
  end

  assign mem_req_valid        = out_valid_q;
  assign mem_req_bits_store   = out_store_q;
  assign mem_req_bits_address = out_addr_q;
  assign mem_req_bits_size    = out_size_q;
  assign mem_req_bits_data    = out_data_q;
  assign mem_req_bits_mask    = out_mask_q;
  assign mem_req_bits_tag     = out_slot_q;

  always_comb begin
    inflight_count = '0;
    for (int s = 0; s < MAX_INFLIGHT; s++)
      if (busy_q[s]) inflight_count = inflight_count + 1'b1;
  end

  assign idle  = (busy_q == '0) && !out_valid_q;
  assign error = error_q;
endmodule

// File: tb/tb_lane_mem_arbiter.sv
// tb_lane_mem_arbiter: directed scenario tests for lane_mem_arbiter with default parameters.
module tb_lane_mem_arbiter;
  logic          clock = 1'b0, reset_n = 1'b0;
  logic [15:0]   lane_req_valid = '0, lane_req_ready, lane_req_bits_store = '0;
  logic [511:0]  lane_req_bits_address = '0, lane_req_bits_data = '0, lane_req_bits_tag = '0;
  logic [31:0]   lane_req_bits_size = '0;
  logic [63:0]   lane_req_bits_mask = '0;
  logic [15:0]   lane_resp_valid, lane_resp_ready = '1;
  logic [511:0]  lane_resp_bits_tag, lane_resp_bits_data;
  logic          mem_req_valid, mem_req_ready = 1'b1, mem_req_bits_store;
  logic [31:0]   mem_req_bits_address, mem_req_bits_data;
  logic [1:0]    mem_req_bits_size;
  logic [3:0]    mem_req_bits_mask;
  logic [2:0]    mem_req_bits_tag, mem_resp_bits_tag = '0;
  logic          mem_resp_valid = 1'b0, mem_resp_ready;
  logic [31:0]   mem_resp_bits_data = '0;
  logic [3:0]    inflight_count;
  logic          idle, error;
  int            checks = 0, failures = 0;

  lane_mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .lane_req_valid(lane_req_valid), .lane_req_ready(lane_req_ready),
    .lane_req_bits_store(lane_req_bits_store), .lane_req_bits_address(lane_req_bits_address),
    .lane_req_bits_size(lane_req_bits_size), .lane_req_bits_data(lane_req_bits_data),
    .lane_req_bits_mask(lane_req_bits_mask), .lane_req_bits_tag(lane_req_bits_tag),
    .lane_resp_valid(lane_resp_valid), .lane_resp_ready(lane_resp_ready),
    .lane_resp_bits_tag(lane_resp_bits_tag), .lane_resp_bits_data(lane_resp_bits_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_bits_store(mem_req_bits_store), .mem_req_bits_address(mem_req_bits_address),
    .mem_req_bits_size(mem_req_bits_size), .mem_req_bits_data(mem_req_bits_data),
    .mem_req_bits_mask(mem_req_bits_mask), .mem_req_bits_tag(mem_req_bits_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_bits_tag(mem_resp_bits_tag), .mem_resp_bits_data(mem_resp_bits_data),
    .inflight_count(inflight_count), .idle(idle), .error(error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] addr_of(input int g);
    return 32'h1000_0000 + 32'(g) * 32'h10;
  endfunction

  function automatic logic [31:0] tag_of(input int g);
    return 32'h0000_7000 + 32'(g);
  endfunction

  task automatic set_lane(input int g, input logic [31:0] t);
    lane_req_bits_address[32*g +: 32] = addr_of(g);
    lane_req_bits_data[32*g +: 32]    = addr_of(g) ^ 32'h5A5A_0000;
    lane_req_bits_tag[32*g +: 32]     = t;
    lane_req_bits_size[2*g +: 2]      = 2'd2;
    lane_req_bits_mask[4*g +: 4]      = 4'hF;
    lane_req_bits_store[g]            = g[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic free_slots(input int n);
    for (int s = 0; s < n; s++) begin
      mem_resp_valid = 1'b1;
      mem_resp_bits_tag = 3'(s);
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (inflight_count !== 4'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight_count); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    checks++; if (lane_resp_valid !== 16'h0) begin failures++; $display("FAIL reset_lane_resp_valid got=%h exp=0", lane_resp_valid); end
    checks++; if (lane_req_ready !== 16'h0) begin failures++; $display("FAIL reset_lane_req_ready got=%h exp=0", lane_req_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int lanes [3] = '{0, 3, 7};
    mem_req_ready  = 1'b1;
    lane_req_valid = 16'h0089;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (lane_req_ready !== (16'd1 << lanes[k])) begin failures++; $display("FAIL rr_ready%0d got=%h exp=%h", k, lane_req_ready, 16'd1 << lanes[k]); end
      tick();
      lane_req_valid[lanes[k]] = 1'b0;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_bits_tag !== 3'(k)) begin failures++; $display("FAIL rr_mem_tag%0d got=%b/%0d exp=1/%0d", k, mem_req_valid, mem_req_bits_tag, k); end
      checks++; if (mem_req_bits_address !== addr_of(lanes[k])) begin failures++; $display("FAIL rr_mem_addr%0d got=%h exp=%h", k, mem_req_bits_address, addr_of(lanes[k])); end
    end
    checks++; if (inflight_count !== 4'd3) begin failures++; $display("FAIL rr_inflight got=%0d exp=3", inflight_count); end
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", mem_req_valid); end
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid     = 1'b1;
      mem_resp_bits_tag  = 3'(k);
      mem_resp_bits_data = 32'hD000_0000 + 32'(k);
      @(negedge clock);
      checks++; if (lane_resp_valid !== (16'd1 << lanes[k])) begin failures++; $display("FAIL route_valid%0d got=%h exp=%h", k, lane_resp_valid, 16'd1 << lanes[k]); end
      checks++; if (lane_resp_bits_tag[32*lanes[k] +: 32] !== tag_of(lanes[k])) begin failures++; $display("FAIL route_tag%0d got=%h exp=%h", k, lane_resp_bits_tag[32*lanes[k] +: 32], tag_of(lanes[k])); end
      checks++; if (lane_resp_bits_data[32*lanes[k] +: 32] !== 32'hD000_0000 + 32'(k)) begin failures++; $display("FAIL route_data%0d got=%h", k, lane_resp_bits_data[32*lanes[k] +: 32]); end
      tick();
    end
    mem_resp_valid = 1'b0;
    checks++; if (inflight_count !== 4'd0 || idle !== 1'b1) begin failures++; $display("FAIL rr_freed got=%0d/%b exp=0/1", inflight_count, idle); end
  endtask

  task automatic test_full();
    lane_req_valid = 16'h0002;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++; if (lane_req_ready !== 16'h0002) begin failures++; $display("FAIL full_ready%0d got=%h exp=0002", k, lane_req_ready); end
      tick();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_bits_tag !== 3'(k)) begin failures++; $display("FAIL b2b_tag%0d got=%b/%0d exp=1/%0d", k, mem_req_valid, mem_req_bits_tag, k); end
    end
    lane_req_valid = 16'h0020;
    @(negedge clock);
    checks++; if (lane_req_ready !== 16'h0) begin failures++; $display("FAIL full_blocked got=%h exp=0000", lane_req_ready); end
    checks++; if (inflight_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", inflight_count); end
    tick();
    mem_resp_valid    = 1'b1;
    mem_resp_bits_tag = 3'd2;
    @(negedge clock);
    checks++; if (lane_resp_valid !== 16'h0002) begin failures++; $display("FAIL full_resp_lane got=%h exp=0002", lane_resp_valid); end
    checks++; if (lane_req_ready !== 16'h0) begin failures++; $display("FAIL full_same_cycle_reuse got=%h exp=0000", lane_req_ready); end
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clock);
    checks++; if (lane_req_ready !== 16'h0020 || inflight_count !== 4'd7) begin failures++; $display("FAIL full_regrant got=%h/%0d exp=0020/7", lane_req_ready, inflight_count); end
    tick();
    lane_req_valid = 16'h0;
    checks++; if (mem_req_bits_tag !== 3'd2 || mem_req_bits_address !== addr_of(5)) begin failures++; $display("FAIL full_slot2 got=%0d/%h exp=2/%h", mem_req_bits_tag, mem_req_bits_address, addr_of(5)); end
    checks++; if (inflight_count !== 4'd8) begin failures++; $display("FAIL full_refill got=%0d exp=8", inflight_count); end
    free_slots(8);
    checks++; if (inflight_count !== 4'd0) begin failures++; $display("FAIL full_freed got=%0d exp=0", inflight_count); end
  endtask

  task automatic test_resp_hold();
    set_lane(4, 32'h0000_ABCD);
    lane_req_valid = 16'h0011;
    @(negedge clock);
    checks++; if (lane_req_ready !== 16'h0001) begin failures++; $display("FAIL hold_wrap_grant got=%h exp=0001", lane_req_ready); end
    tick();
    @(negedge clock);
    checks++; if (lane_req_ready !== 16'h0010) begin failures++; $display("FAIL hold_lane4_grant got=%h exp=0010", lane_req_ready); end
    tick();
    lane_req_valid = 16'h0;
    checks++; if (mem_req_bits_tag !== 3'd1) begin failures++; $display("FAIL hold_slot got=%0d exp=1", mem_req_bits_tag); end
    lane_resp_ready    = 16'h0;
    mem_resp_valid     = 1'b1;
    mem_resp_bits_tag  = 3'd1;
    mem_resp_bits_data = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (lane_resp_valid !== 16'h0010 || mem_resp_ready !== 1'b0) begin failures++; $display("FAIL hold_stall%0d got=%h/%b exp=0010/0", c, lane_resp_valid, mem_resp_ready); end
      checks++; if (lane_resp_bits_tag[128 +: 32] !== 32'h0000_ABCD || lane_resp_bits_data[128 +: 32] !== 32'h1234_5678) begin failures++; $display("FAIL hold_payload%0d got=%h/%h", c, lane_resp_bits_tag[128 +: 32], lane_resp_bits_data[128 +: 32]); end
      tick();
    end
    checks++; if (inflight_count !== 4'd2) begin failures++; $display("FAIL hold_not_freed got=%0d exp=2", inflight_count); end
    lane_resp_ready = 16'hFFFF;
    @(negedge clock);
    checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%b exp=1", mem_resp_ready); end
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (inflight_count !== 4'd1) begin failures++; $display("FAIL hold_freed got=%0d exp=1", inflight_count); end
    free_slots(1);
    set_lane(4, tag_of(4));
  endtask

  task automatic test_backpressure();
    mem_req_ready  = 1'b0;
    lane_req_valid = 16'h0004;
    @(negedge clock);
    checks++; if (lane_req_ready !== 16'h0004) begin failures++; $display("FAIL bp_first_grant got=%h exp=0004", lane_req_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++; if (lane_req_ready !== 16'h0) begin failures++; $display("FAIL bp_ready%0d got=%h exp=0000", c, lane_req_ready); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_bits_address !== addr_of(2) || mem_req_bits_tag !== 3'd0
                    || mem_req_bits_data !== (addr_of(2) ^ 32'h5A5A_0000) || mem_req_bits_store !== 1'b0) begin
        failures++; $display("FAIL bp_stable%0d got=%b/%h/%0d", c, mem_req_valid, mem_req_bits_address, mem_req_bits_tag);
      end
      tick();
    end
    checks++; if (inflight_count !== 4'd1) begin failures++; $display("FAIL bp_one_grant got=%0d exp=1", inflight_count); end
    lane_req_valid = 16'h0;
    mem_req_ready  = 1'b1;
    tick();
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b exp=0", mem_req_valid); end
    free_slots(1);
  endtask

  task automatic test_error();
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_clean got=%b exp=0", error); end
    mem_resp_valid    = 1'b1;
    mem_resp_bits_tag = 3'd6;
    @(negedge clock);
    checks++; if (lane_resp_valid !== 16'h0 || mem_resp_ready !== 1'b1) begin failures++; $display("FAIL err_drop got=%h/%b exp=0000/1", lane_resp_valid, mem_resp_ready); end
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (error !== 1'b1 || inflight_count !== 4'd0) begin failures++; $display("FAIL err_set got=%b/%0d exp=1/0", error, inflight_count); end
    tick();
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", error); end
  endtask

  task automatic test_reset_mid();
    lane_req_valid = 16'h0002;
    repeat (3) tick();
    checks++; if (inflight_count !== 4'd3 || mem_req_valid !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0d/%b exp=3/1", inflight_count, mem_req_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || inflight_count !== 4'd0 || idle !== 1'b1 || error !== 1'b0) begin
      failures++; $display("FAIL rst_async got=%b/%0d/%b/%b exp=0/0/1/0", mem_req_valid, inflight_count, idle, error);
    end
    lane_req_valid = 16'h0;
    tick();
    reset_n = 1'b1;
    tick();
    mem_resp_valid    = 1'b1;
    mem_resp_bits_tag = 3'd0;
    @(negedge clock);
    checks++; if (lane_resp_valid !== 16'h0) begin failures++; $display("FAIL rst_stale_resp got=%h exp=0000", lane_resp_valid); end
    tick();
    mem_resp_valid = 1'b0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL rst_stale_error got=%b exp=1", error); end
  endtask

  initial begin
    for (int g = 0; g < 16; g++) set_lane(g, tag_of(g));
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_round_robin();
    test_full();
    test_resp_hold();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_mem_arbiter.md
LANE_MEM_ARBITER -- requirements
Module: lane_mem_arbiter

Interface
REQ-001 Parameter NUM_LANES, default 16: number of per-lane request/response channels.
REQ-002 Parameter ARCH_LEN, default 32: address width.
REQ-003 Parameter DMEM_DATA_BITS, default 32: data width; MASK_BITS = DMEM_DATA_BITS/8; SIZE_BITS = $clog2($clog2(MASK_BITS)+1).
REQ-004 Parameter DMEM_TAG_BITS, default 32: per-lane tag width.
REQ-005 Parameter MAX_INFLIGHT, default 8: outstanding downstream requests; SLOT_BITS = $clog2(MAX_INFLIGHT).
REQ-006 Ports, clock and reset first; one clock; reset is asynchronous and active-low:
- clock, input, 1, sole clock.
- reset_n, input, 1, asynchronous active-low reset.
- lane_req_valid/ready, in/out, NUM_LANES, per-lane request handshake.
- lane_req_bits_{store,address,size,data,mask,tag}, input, NUM_LANES x field width, flattened lane g at [W*g +: W].
- lane_resp_valid, output, NUM_LANES, per-lane response valid.
- lane_resp_ready, input, NUM_LANES, per-lane response ready.
- lane_resp_bits_{tag,data}, output, NUM_LANES x DMEM_TAG_BITS/DMEM_DATA_BITS, returned tag and data.
- mem_req_valid/ready, out/in, 1, downstream request handshake.
- mem_req_bits_{store,address,size,data,mask}, output, field widths, downstream request.
- mem_req_bits_tag, output, SLOT_BITS, downstream slot ID.
- mem_resp_valid/ready, in/out, 1, downstream response handshake.
- mem_resp_bits_tag, input, SLOT_BITS, slot ID.
- mem_resp_bits_data, input, DMEM_DATA_BITS, response data.
- inflight_count, output, $clog2(MAX_INFLIGHT+1), busy slot count.
- idle, output, 1, no busy slot and output register empty.
- error, output, 1, sticky flag: response to a non-busy slot.

Function
REQ-007 Round-robin arbitration across lanes with lane_req_valid; search starts at rr_ptr; after a grant to lane i, rr_ptr becomes (i+1) mod NUM_LANES; rr_ptr unchanged when nothing granted.
REQ-008 Grant allowed only when a free slot exists AND (output register empty OR mem_req_ready); lane_req_ready is high only for the granted lane, combinational from the valid vector.
REQ-009 On grant: allocate lowest-index free slot, record {lane_id, lane_tag} in slot table, mark busy, load output register with request fields and tag = slot ID.
REQ-010 Latency: lane accept in cycle N -> mem_req_valid in cycle N+1; holds all mem_req fields stable until mem_req_ready.
REQ-011 Back-to-back: output register accepted downstream and reloaded in the same cycle -> one request per cycle sustained.
REQ-012 Stores and loads both occupy a slot and expect a downstream response.
REQ-013 Response routing: mem_resp for a busy slot asserts lane_resp_valid only on the recorded lane, with the recorded tag and mem_resp_bits_data; combinational pass-through.
REQ-014 mem_resp_ready = lane_resp_ready of the recorded lane; slot freed on the mem_resp handshake.
REQ-015 Slot freed and allocated in the same cycle: allocation uses pre-free busy vector; freed slot is reusable next cycle.
REQ-016 All MAX_INFLIGHT slots busy -> all lane_req_ready low; no grant, no rr_ptr change.
REQ-017 mem_resp to a non-busy slot: mem_resp_ready high (dropped), no lane_resp_valid, error set until reset.
REQ-018 inflight_count = popcount(busy); increments on allocation, decrements on free, unchanged on both in the same cycle.

Reset
REQ-019 On reset_n low, asynchronously: output register valid 0, busy vector 0, rr_ptr 0, error 0; thus mem_req_valid 0, lane_resp_valid 0, inflight_count 0, idle 1.
REQ-020 Reset mid-operation discards all in-flight slots; responses arriving after reset release are treated per REQ-017.

Structure
REQ-021 Package lane_mem_arbiter_pkg holds parameter defaults, the derived widths, and typedef slot_entry_t {lane_id, lane_tag}.
REQ-022 Sub-module rr_arbiter (NUM_LANES requests, pointer in, one-hot grant out) is instantiated once.

Verification
REQ-023 Lanes 0, 3, 7 valid together, rr_ptr=0, mem_req_ready=1 -> grants 0, 3, 7 in consecutive cycles, mem tags 0, 1, 2.
REQ-024 8 requests issued, no responses; lane 5 valid -> lane_req_ready[5]=0 and inflight_count=8; response slot 2 -> next cycle lane 5 granted with slot 2.
REQ-025 Lane 4 tag 0xABCD assigned slot 1; mem_resp tag=1, data=0x12345678, lane_resp_ready[4]=0 for 3 cycles -> lane_resp_valid[4] held, mem_resp_ready=0; frees on the 4th cycle.
REQ-026 mem_req_ready=0 for 5 cycles with lane 2 valid -> mem_req fields stable, one grant only, lane_req_ready[2]=0 after the first grant.
REQ-027 mem_resp tag=6 while slot 6 is free -> error=1, no lane_resp_valid, inflight_count unchanged.
REQ-028 reset_n low mid-burst with 3 slots busy -> same cycle mem_req_valid=0, inflight_count=0, idle=1.
